// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM states, access sizes,
// requester ids and the size-to-beat-count helper.
// No ports; imported by dmem_ctrl and rr_arbiter2.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  // Encoding 2'b11 is not a legal size and falls through to a full word.
  function automatic logic [2:0] size_to_beats(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_to_beats = 3'd1;
      SZ_HALF: size_to_beats = 3'd2;
      default: size_to_beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational from the requests.
// Latency: 0 cycles (grant), pointer moves on the edge a grant is accepted.
// Backpressure: pointer holds until i_accept, so an unaccepted grant is not consumed.
// Ports: i_clk/i_rst clock and sync reset, i_req_cpu/i_req_dbg requests,
//        i_accept consumer takes the grant, o_grant_vld/o_grant (0=cpu,1=dbg).
module rr_arbiter2
  import dmem_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_cpu,
  input  logic i_req_dbg,
  input  logic i_accept,
  output logic o_grant_vld,
  output logic o_grant
);

  // Requester favoured on a tie; the one not granted last time.
  logic r_prio;

  always_comb begin
    o_grant_vld = i_req_cpu | i_req_dbg;
    if (i_req_cpu && i_req_dbg) begin
      o_grant = r_prio;
    end else if (i_req_dbg) begin
      o_grant = REQ_DBG;
    end else begin
      o_grant = REQ_CPU;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= REQ_CPU;
    end else if (i_accept && o_grant_vld) begin
      r_prio <= ~o_grant;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbitrates cpu/dbg ports onto a byte-wide sync memory, one byte beat per cycle.
// Latency: ack at t+1+nbeats after the IDLE sample (byte 2, half 3, word 4+1 cycles).
// Backpressure: requester holds req until its one-cycle ack; cpu_stall covers the wait.
// Ports: clock/reset; cpu_* and dbg_* request ports (req/we/size/addr/wdata in,
//        ack/rdata out); cpu_stall; mem_addr/mem_we/mem_wdata out, mem_rdata in.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic [2:0]        r_nbeats;
  logic [2:0]        r_beat;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;

  logic              w_gnt_vld;
  logic              w_gnt;
  logic              w_accept;
  logic              w_sel_we;
  logic [1:0]        w_sel_size;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [2:0]        w_beat_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_last;
  logic [1:0]        w_prev_idx;
  logic [31:0]       w_rdata_fin;

  assign w_accept = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_req_cpu   (cpu_req),
    .i_req_dbg   (dbg_req),
    .i_accept    (w_accept),
    .o_grant_vld (w_gnt_vld),
    .o_grant     (w_gnt)
  );

  always_comb begin
    if (w_gnt == REQ_DBG) begin
      w_sel_we    = dbg_we;
      w_sel_size  = dbg_size;
      w_sel_addr  = dbg_addr;
      w_sel_wdata = dbg_wdata;
    end else begin
      w_sel_we    = cpu_we;
      w_sel_size  = cpu_size;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
    end
  end

  assign w_beat_nxt = r_beat + 3'd1;
  // Address arithmetic is deliberately truncated so a burst wraps at the top of memory.
  assign w_addr_nxt = r_base + ADDR_W'(w_beat_nxt);
  assign w_last     = (r_beat == r_nbeats - 3'd1);
  // Sync memory: the byte on mem_rdata belongs to the address of the previous beat.
  assign w_prev_idx = r_beat[1:0] - 2'd1;

  // The last load byte arrives during FINISH, so it is merged here rather than buffered.
  always_comb begin
    w_rdata_fin = r_rbuf;
    case (r_nbeats)
      3'd1:    w_rdata_fin[7:0]   = mem_rdata;
      3'd2:    w_rdata_fin[15:8]  = mem_rdata;
      default: w_rdata_fin[31:24] = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= REQ_CPU;
      r_we        <= 1'b0;
      r_nbeats    <= 3'd0;
      r_beat      <= 3'd0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_rbuf      <= 32'd0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
          if (w_gnt_vld) begin
            r_owner     <= w_gnt;
            r_we        <= w_sel_we;
            r_nbeats    <= size_to_beats(w_sel_size);
            r_beat      <= 3'd0;
            r_base      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_rbuf      <= 32'd0;
            // Beat 0 is presented on the memory port as ACCESS is entered.
            r_mem_addr  <= w_sel_addr;
            r_mem_we    <= w_sel_we;
            r_mem_wdata <= w_sel_wdata[7:0];
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we && (r_beat != 3'd0)) begin
            r_rbuf[{w_prev_idx, 3'b000} +: 8] <= mem_rdata;
          end
          if (w_last) begin
            r_mem_we <= 1'b0;
            if (r_owner == REQ_DBG) begin
              r_dbg_ack <= 1'b1;
            end else begin
              r_cpu_ack <= 1'b1;
            end
            r_state <= FINISH;
          end else begin
            r_beat      <= w_beat_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= r_wdata[{w_beat_nxt[1:0], 3'b000} +: 8];
          end
        end
        default: begin
          r_cpu_ack <= 1'b0;
          r_dbg_ack <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = (r_cpu_ack && !r_we) ? w_rdata_fin : 32'd0;
  assign dbg_rdata = (r_dbg_ack && !r_we) ? w_rdata_fin : 32'd0;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign mem_addr  = r_mem_addr;
  // Gated by reset so an in-flight beat is not written on the cycle reset is seen.
  assign mem_we    = r_mem_we & ~reset;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int AW = 10;
  localparam int MEMSZ = 1024;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [1:0]    cpu_size, dbg_size;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [31:0]   cpu_wdata, dbg_wdata;
  logic          cpu_ack, dbg_ack, cpu_stall;
  logic [31:0]   cpu_rdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;

  logic [7:0]    ram     [0:MEMSZ-1];
  logic [7:0]    ref_mem [0:MEMSZ-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_dat = 8'd0;

  int   checks = 0;
  int   failures = 0;
  logic last_gnt = 1'b1;  // 0 cpu, 1 dbg: "dbg last" means cpu wins the next tie

  always #5 clock = ~clock;

  dmem_ctrl #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-wide synchronous RAM with a side port for preloading.
  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Transaction-level effect of one access on the reference memory.
  task automatic model_apply(input logic we, input logic [1:0] sz, input int addr,
                             input logic [31:0] wd, output logic [31:0] rd);
    int a;
    rd = 32'd0;
    for (int i = 0; i < nb(sz); i++) begin
      a = (addr + i) % MEMSZ;
      if (we) ref_mem[a] = wd[8*i +: 8];
      else    rd[8*i +: 8] = ref_mem[a];
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = AW'(a); pre_dat = d;
    ref_mem[a] = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic p, input logic r, input logic we, input logic [1:0] sz,
                       input int a, input logic [31:0] wd);
    if (p) begin
      dbg_req = r; dbg_we = we; dbg_size = sz; dbg_addr = AW'(a); dbg_wdata = wd;
    end else begin
      cpu_req = r; cpu_we = we; cpu_size = sz; cpu_addr = AW'(a); cpu_wdata = wd;
    end
  endtask

  task automatic wait_ack(input logic p, input int budget, output int n, output int sc);
    logic got;
    n = 0; sc = 0; got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clock); n++;
      @(negedge clock);
      got = p ? dbg_ack : cpu_ack;
      if (!got && cpu_stall) sc++;
    end
  endtask

  task automatic chk_bytes(input string tag, input int addr);
    int a;
    for (int i = 0; i < 5; i++) begin
      a = (addr + i) % MEMSZ;
      chk({tag, "_mem"}, {24'd0, ram[a]}, {24'd0, ref_mem[a]});
    end
  endtask

  task automatic run_single(input logic p, input logic we, input logic [1:0] sz, input int addr,
                            input logic [31:0] wd, input string tag, output logic [31:0] rd_obs);
    logic [31:0] exp;
    int n, sc, s0;
    model_apply(we, sz, addr, wd, exp);
    drive(p, 1'b1, we, sz, addr, wd);
    #1;
    s0 = cpu_stall ? 1 : 0;
    wait_ack(p, 20, n, sc);
    rd_obs = p ? dbg_rdata : cpu_rdata;
    chk({tag, "_lat"}, n, nb(sz) + 1);
    chk({tag, "_rdata"}, rd_obs, exp);
    chk({tag, "_stall_cnt"}, s0 + sc, p ? 0 : nb(sz) + 1);
    chk({tag, "_stall_ack"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_other_ack"}, {31'd0, p ? cpu_ack : dbg_ack}, 32'd0);
    drive(p, 1'b0, we, sz, addr, wd);
    chk_bytes(tag, addr);
    last_gnt = p;
    @(posedge clock); @(negedge clock);
  endtask

  task automatic run_both(input logic cwe, input logic [1:0] csz, input int ca, input logic [31:0] cwd,
                          input logic dwe, input logic [1:0] dsz, input int da, input logic [31:0] dwd);
    logic w, gc, gd;
    logic [31:0] crd, drd;
    int n, nc, nd, lw, ll;
    w = ~last_gnt;
    if (!w) begin
      model_apply(cwe, csz, ca, cwd, crd);
      model_apply(dwe, dsz, da, dwd, drd);
      lw = nb(csz) + 1; ll = lw + nb(dsz) + 2;
    end else begin
      model_apply(dwe, dsz, da, dwd, drd);
      model_apply(cwe, csz, ca, cwd, crd);
      lw = nb(dsz) + 1; ll = lw + nb(csz) + 2;
    end
    drive(1'b0, 1'b1, cwe, csz, ca, cwd);
    drive(1'b1, 1'b1, dwe, dsz, da, dwd);
    n = 0; nc = 0; nd = 0; gc = 1'b0; gd = 1'b0;
    while (!(gc && gd) && n < 40) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (!gc && cpu_ack) begin
        gc = 1'b1; nc = n;
        chk("both_cpu_rdata", cpu_rdata, crd);
        drive(1'b0, 1'b0, cwe, csz, ca, cwd);
      end
      if (!gd && dbg_ack) begin
        gd = 1'b1; nd = n;
        chk("both_dbg_rdata", dbg_rdata, drd);
        drive(1'b1, 1'b0, dwe, dsz, da, dwd);
      end
    end
    drive(1'b0, 1'b0, cwe, csz, ca, cwd);
    drive(1'b1, 1'b0, dwe, dsz, da, dwd);
    chk("both_cpu_lat", nc, w ? ll : lw);
    chk("both_dbg_lat", nd, w ? lw : ll);
    chk_bytes("both_cpu", ca);
    chk_bytes("both_dbg", da);
    last_gnt = ~w;
    @(posedge clock); @(negedge clock);
  endtask

  initial begin
    logic [31:0] rd, e1, e2, e3;
    int n, sc;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 0, 32'd0);
    @(negedge clock);
    for (int i = 0; i < MEMSZ; i++) poke(i, 8'($urandom));

    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Tie right after reset: cpu first; cpu re-requests at once, then dbg wins.
    poke(40, 8'hFF); poke(41, 8'h00); poke(42, 8'hFF); poke(43, 8'h00);
    model_apply(1'b0, 2'd2, 40, 32'd0, e1);
    model_apply(1'b1, 2'd2, 500, 32'hCAFEF00D, e2);
    model_apply(1'b0, 2'd2, 500, 32'd0, e3);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 40, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 500, 32'hCAFEF00D);
    wait_ack(1'b0, 20, n, sc);
    chk("arb_cpu_lat", n, 5);
    chk("arb_cpu_rdata", cpu_rdata, e1);
    chk("word_load_const", cpu_rdata, 32'h00FF00FF);
    chk("arb_dbg_waits", {31'd0, dbg_ack}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 500, 32'd0);
    wait_ack(1'b1, 20, n, sc);
    chk("arb_dbg_lat", n, 6);
    chk("arb_dbg_rdata", dbg_rdata, e2);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 0, 32'd0);
    wait_ack(1'b0, 20, n, sc);
    chk("arb_cpu2_lat", n, 6);
    chk("arb_cpu2_rdata", cpu_rdata, e3);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 32'd0);
    last_gnt = 1'b0;
    @(posedge clock); @(negedge clock);

    run_single(1'b0, 1'b1, 2'd2, 100, 32'h00FF01FF, "word_store", rd);
    chk("word_store_b0", {24'd0, ram[100]}, 32'hFF);
    chk("word_store_b3", {24'd0, ram[103]}, 32'h00);
    run_single(1'b0, 1'b0, 2'd0, 101, 32'd0, "byte_load", rd);
    chk("byte_load_const", rd, 32'h00000001);
    run_single(1'b0, 1'b1, 2'd1, 200, 32'h1234ABCD, "half_store", rd);
    run_single(1'b1, 1'b1, 2'd2, 1022, 32'h11223344, "wrap_store", rd);
    chk("wrap_b1022", {24'd0, ram[1022]}, 32'h44);
    chk("wrap_b0", {24'd0, ram[0]}, 32'h22);
    chk("wrap_b1", {24'd0, ram[1]}, 32'h11);
    run_single(1'b1, 1'b0, 2'd3, 1022, 32'd0, "size3_load", rd);
    chk("size3_const", rd, 32'h11223344);
    run_single(1'b0, 1'b0, 2'd1, 1023, 32'd0, "half_wrap_load", rd);

    // Reset during beat 2 of a word store.
    for (int i = 300; i < 304; i++) poke(i, 8'hAA);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 300, 32'h55667788);
    repeat (3) begin @(posedge clock); @(negedge clock); end
    chk("rst_mid_we_before", {31'd0, mem_we}, 32'd1);
    chk("rst_mid_addr", {22'd0, mem_addr}, 32'd302);
    reset = 1'b1;
    #1;
    chk("rst_mid_we_same", {31'd0, mem_we}, 32'd0);
    @(posedge clock); @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 32'd0);
    chk("rst_mid_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_mid_we_after", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    ref_mem[300] = 8'h88; ref_mem[301] = 8'h77;
    chk_bytes("rst_mid", 300);
    last_gnt = 1'b1;
    @(negedge clock);
    run_single(1'b0, 1'b0, 2'd2, 300, 32'd0, "post_rst_load", rd);
    chk("post_rst_const", rd, 32'hAAAA7788);

    // Ties after a single op: the other requester goes first.
    run_both(1'b1, 2'd2, 700, 32'h01020304, 1'b1, 2'd2, 702, 32'hA0B0C0D0);

    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 2)
        run_both(1'($urandom), 2'($urandom), $urandom_range(0, MEMSZ-1), $urandom,
                 1'($urandom), 2'($urandom), $urandom_range(0, MEMSZ-1), $urandom);
      else
        run_single(mode[0], 1'($urandom), 2'($urandom), $urandom_range(0, MEMSZ-1), $urandom,
                   "rand", rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
